// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse packet integrator: clamped cursor position plus draw requests while left is held.
// Build option: define CURSOR_ACCEL_EN to double deltas whose magnitude exceeds ACCEL_THRESH.
module mouse_cursor_tracker #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int COORD_BITS   = 10,
    parameter int INIT_X       = 320,
    parameter int INIT_Y       = 240,
    parameter int ACCEL_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_ready,
    output logic                  read,
    input  logic [8:0]            x_increment,
    input  logic [8:0]            y_increment,
    input  logic                  left_button_in,
    input  logic                  right_button_in,
    output logic [COORD_BITS-1:0] cursor_x,
    output logic [COORD_BITS-1:0] cursor_y,
    output logic                  left_button,
    output logic                  right_button,
    output logic                  cursor_moved,
    output logic                  draw_valid,
    input  logic                  draw_ready,
    output logic [COORD_BITS-1:0] draw_x,
    output logic [COORD_BITS-1:0] draw_y,
    output logic [1:0]            o_state
);

    // Handshakes: a packet is taken when data_ready=1 in S_IDLE and acknowledged by a
    // one-cycle read; a draw transfers on the clk edge where draw_valid=1 and draw_ready=1,
    // and draw_x/draw_y hold steady for as long as draw_valid stays high.

    localparam int CW = COORD_BITS + 2;
    localparam logic signed [CW-1:0] MAX_X = CW'(SCREEN_W - 1);
    localparam logic signed [CW-1:0] MAX_Y = CW'(SCREEN_H - 1);
    localparam logic signed [CW-1:0] THR   = CW'(ACCEL_THRESH);
`ifdef CURSOR_ACCEL_EN
    localparam bit ACCEL_ON = 1'b1;
`else
    localparam bit ACCEL_ON = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_UPDATE, S_DRAW} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [8:0]              r_dx;
    logic [8:0]              r_dy;
    logic                    r_lb_lat;
    logic                    r_rb_lat;
    logic [COORD_BITS-1:0]   r_cursor_x;
    logic [COORD_BITS-1:0]   r_cursor_y;
    logic                    r_left;
    logic                    r_right;
    logic                    r_moved;
    logic [COORD_BITS-1:0]   r_draw_x;
    logic [COORD_BITS-1:0]   r_draw_y;

    logic signed [CW-1:0]    w_dx_ext;
    logic signed [CW-1:0]    w_dy_ext;
    logic signed [CW-1:0]    w_dx_mag;
    logic signed [CW-1:0]    w_dy_mag;
    logic signed [CW-1:0]    w_dx_eff;
    logic signed [CW-1:0]    w_dy_eff;
    logic signed [CW-1:0]    w_nx;
    logic signed [CW-1:0]    w_ny;
    logic [COORD_BITS-1:0]   w_cx;
    logic [COORD_BITS-1:0]   w_cy;

    function automatic logic [COORD_BITS-1:0] clamp(input logic signed [CW-1:0] v,
                                                     input logic signed [CW-1:0] vmax);
        if (v[CW-1])
            return '0;
        else if (v > vmax)
            return vmax[COORD_BITS-1:0];
        else
            return v[COORD_BITS-1:0];
    endfunction

    // Widened signed arithmetic so that add/subtract and the optional doubling never wrap.
    assign w_dx_ext = {{(CW-9){r_dx[8]}}, r_dx};
    assign w_dy_ext = {{(CW-9){r_dy[8]}}, r_dy};
    assign w_dx_mag = r_dx[8] ? -w_dx_ext : w_dx_ext;
    assign w_dy_mag = r_dy[8] ? -w_dy_ext : w_dy_ext;
    assign w_dx_eff = (ACCEL_ON && (w_dx_mag > THR)) ? (w_dx_ext <<< 1) : w_dx_ext;
    assign w_dy_eff = (ACCEL_ON && (w_dy_mag > THR)) ? (w_dy_ext <<< 1) : w_dy_ext;
    assign w_nx     = $signed({2'b00, r_cursor_x}) + w_dx_eff;
    assign w_ny     = $signed({2'b00, r_cursor_y}) - w_dy_eff;
    assign w_cx     = clamp(w_nx, MAX_X);
    assign w_cy     = clamp(w_ny, MAX_Y);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (data_ready) w_state_next = S_ACK;
            S_ACK:    w_state_next = S_UPDATE;
            S_UPDATE: w_state_next = r_lb_lat ? S_DRAW : S_IDLE;
            S_DRAW:   if (draw_ready) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_dx       <= '0;
            r_dy       <= '0;
            r_lb_lat   <= 1'b0;
            r_rb_lat   <= 1'b0;
            r_cursor_x <= COORD_BITS'(INIT_X);
            r_cursor_y <= COORD_BITS'(INIT_Y);
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_moved    <= 1'b0;
            r_draw_x   <= '0;
            r_draw_y   <= '0;
        end else begin
            r_state <= w_state_next;
            r_moved <= 1'b0;
            if (r_state == S_IDLE && data_ready) begin
                r_dx     <= x_increment;
                r_dy     <= y_increment;
                r_lb_lat <= left_button_in;
                r_rb_lat <= right_button_in;
            end
            if (r_state == S_UPDATE) begin
                r_cursor_x <= w_cx;
                r_cursor_y <= w_cy;
                r_left     <= r_lb_lat;
                r_right    <= r_rb_lat;
                r_moved    <= (w_cx != r_cursor_x) || (w_cy != r_cursor_y);
                if (r_lb_lat) begin
                    r_draw_x <= w_cx;
                    r_draw_y <= w_cy;
                end
            end
        end
    end

    assign read         = (r_state == S_ACK);
    assign draw_valid   = (r_state == S_DRAW);
    assign cursor_x     = r_cursor_x;
    assign cursor_y     = r_cursor_y;
    assign left_button  = r_left;
    assign right_button = r_right;
    assign cursor_moved = r_moved;
    assign draw_x       = r_draw_x;
    assign draw_y       = r_draw_y;
    assign o_state      = r_state;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed self-checking bench for mouse_cursor_tracker; expectations follow CURSOR_ACCEL_EN.
module tb_mouse_cursor_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_ready = 1'b0;
    logic       read;
    logic [8:0] x_increment = '0;
    logic [8:0] y_increment = '0;
    logic       left_button_in = 1'b0;
    logic       right_button_in = 1'b0;
    logic [9:0] cursor_x, cursor_y, draw_x, draw_y;
    logic       left_button, right_button, cursor_moved, draw_valid;
    logic       draw_ready = 1'b0;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_read   = 0;
    int n_moved  = 0;

    mouse_cursor_tracker dut (
        .clk(clk), .reset(reset), .data_ready(data_ready), .read(read),
        .x_increment(x_increment), .y_increment(y_increment),
        .left_button_in(left_button_in), .right_button_in(right_button_in),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .left_button(left_button), .right_button(right_button),
        .cursor_moved(cursor_moved), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .o_state(o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (read === 1'b1) n_read++;
        if (cursor_moved === 1'b1) n_moved++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        data_ready = 1'b0;
        draw_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_packet(input int dx, input int dy, input logic lb, input logic rb);
        x_increment     = 9'(dx);
        y_increment     = 9'(dy);
        left_button_in  = lb;
        right_button_in = rb;
        data_ready      = 1'b1;
    endtask

    // Waits (bounded) for the acknowledge, drops data_ready, and stops right after the update edge.
    task automatic finish_packet(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (read === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL %s_read: read never pulsed, got 0 required 1", name);
        end
        data_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_packet(input string name, input int dx, input int dy,
                               input logic lb, input logic rb);
        start_packet(dx, dy, lb, rb);
        finish_packet(name);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (cursor_x !== 10'd320) begin n_errors++; $display("FAIL rst_x: got %0d required 320", cursor_x); end
        n_checks++; if (cursor_y !== 10'd240) begin n_errors++; $display("FAIL rst_y: got %0d required 240", cursor_y); end
        n_checks++; if (read !== 1'b0) begin n_errors++; $display("FAIL rst_read: got %b required 0", read); end
        n_checks++; if (draw_valid !== 1'b0) begin n_errors++; $display("FAIL rst_dv: got %b required 0", draw_valid); end
        n_checks++; if (draw_x !== 10'd0 || draw_y !== 10'd0) begin n_errors++; $display("FAIL rst_draw: got (%0d,%0d) required (0,0)", draw_x, draw_y); end
        n_checks++; if (left_button !== 1'b0 || right_button !== 1'b0) begin n_errors++; $display("FAIL rst_btn: got %b%b required 00", left_button, right_button); end
        n_checks++; if (cursor_moved !== 1'b0) begin n_errors++; $display("FAIL rst_moved: got %b required 0", cursor_moved); end
        n_checks++; if (o_state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d required 0", o_state); end
    endtask

    task automatic test_basic_move();
        int rd0;
        logic [9:0] ex;
`ifdef CURSOR_ACCEL_EN
        ex = 10'd340;
`else
        ex = 10'd330;
`endif
        apply_reset();
        rd0 = n_read;
        draw_ready = 1'b1;  // must be ignored while no draw is pending
        send_packet("basic", 10, 5, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== ex || cursor_y !== 10'd235) begin n_errors++; $display("FAIL basic_pos: got (%0d,%0d) required (%0d,235)", cursor_x, cursor_y, ex); end
        n_checks++; if (n_read - rd0 !== 1) begin n_errors++; $display("FAIL basic_nread: got %0d required 1", n_read - rd0); end
        n_checks++; if (cursor_moved !== 1'b1) begin n_errors++; $display("FAIL basic_moved: got %b required 1", cursor_moved); end
        n_checks++; if (draw_valid !== 1'b0) begin n_errors++; $display("FAIL basic_dv: got %b required 0", draw_valid); end
        tick();
        n_checks++; if (cursor_moved !== 1'b0) begin n_errors++; $display("FAIL basic_moved_pulse: got %b required 0", cursor_moved); end
        draw_ready = 1'b0;
        send_packet("btn", 0, 0, 1'b0, 1'b1);
        n_checks++; if (right_button !== 1'b1 || left_button !== 1'b0) begin n_errors++; $display("FAIL zero_btn: got l=%b r=%b required l=0 r=1", left_button, right_button); end
        n_checks++; if (cursor_moved !== 1'b0) begin n_errors++; $display("FAIL zero_moved: got %b required 0", cursor_moved); end
    endtask

    task automatic test_clamp();
        logic [9:0] ex_a, ey_d;
`ifdef CURSOR_ACCEL_EN
        ex_a = 10'd0;
        ey_d = 10'd479;
`else
        ex_a = 10'd64;
        ey_d = 10'd259;
`endif
        apply_reset();
        send_packet("clampA", -256, 255, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== ex_a || cursor_y !== 10'd0) begin n_errors++; $display("FAIL clamp_a: got (%0d,%0d) required (%0d,0)", cursor_x, cursor_y, ex_a); end
        send_packet("clampB", -256, 0, 1'b0, 1'b0);
        send_packet("clampC", 5, -3, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== 10'd5 || cursor_y !== 10'd3) begin n_errors++; $display("FAIL clamp_c: got (%0d,%0d) required (5,3)", cursor_x, cursor_y); end
        send_packet("clampD", -256, -256, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== 10'd0 || cursor_y !== ey_d) begin n_errors++; $display("FAIL clamp_d: got (%0d,%0d) required (0,%0d)", cursor_x, cursor_y, ey_d); end
        n_checks++; if (cursor_moved !== 1'b1) begin n_errors++; $display("FAIL clamp_d_moved: got %b required 1", cursor_moved); end
        send_packet("sat1", 255, 0, 1'b0, 1'b0);
        send_packet("sat2", 255, 0, 1'b0, 1'b0);
        send_packet("sat3", 255, 0, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== 10'd639) begin n_errors++; $display("FAIL sat3_x: got %0d required 639", cursor_x); end
        send_packet("sat4", 255, 0, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== 10'd639 || cursor_y !== ey_d) begin n_errors++; $display("FAIL sat4_pos: got (%0d,%0d) required (639,%0d)", cursor_x, cursor_y, ey_d); end
        n_checks++; if (cursor_moved !== 1'b0) begin n_errors++; $display("FAIL sat4_moved: got %b required 0", cursor_moved); end
    endtask

    task automatic test_draw_backpressure();
        int rd0;
        apply_reset();
        send_packet("draw1", 1, 0, 1'b1, 1'b0);
        n_checks++; if (draw_valid !== 1'b1) begin n_errors++; $display("FAIL draw1_dv: got %b required 1", draw_valid); end
        n_checks++; if (draw_x !== 10'd321 || draw_y !== 10'd240) begin n_errors++; $display("FAIL draw1_xy: got (%0d,%0d) required (321,240)", draw_x, draw_y); end
        n_checks++; if (cursor_x !== 10'd321 || left_button !== 1'b1) begin n_errors++; $display("FAIL draw1_cur: got x=%0d l=%b required x=321 l=1", cursor_x, left_button); end
        rd0 = n_read;
        start_packet(0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (draw_valid !== 1'b1 || draw_x !== 10'd321 || draw_y !== 10'd240) begin n_errors++; $display("FAIL hold%0d: got dv=%b (%0d,%0d) required dv=1 (321,240)", i, draw_valid, draw_x, draw_y); end
            n_checks++; if (n_read !== rd0) begin n_errors++; $display("FAIL hold%0d_read: got %0d reads required 0", i, n_read - rd0); end
        end
        draw_ready = 1'b1;
        tick();
        draw_ready = 1'b0;
        n_checks++; if (draw_valid !== 1'b0 || o_state !== 2'd0) begin n_errors++; $display("FAIL release: got dv=%b state=%0d required dv=0 state=0", draw_valid, o_state); end
        finish_packet("draw2");
        n_checks++; if (n_read - rd0 !== 1 || left_button !== 1'b0 || draw_valid !== 1'b0) begin n_errors++; $display("FAIL draw2: got reads=%0d l=%b dv=%b required 1 0 0", n_read - rd0, left_button, draw_valid); end
        send_packet("draw3", 0, 0, 1'b1, 1'b0);
        n_checks++; if (draw_valid !== 1'b1 || draw_x !== 10'd321 || draw_y !== 10'd240 || cursor_moved !== 1'b0) begin n_errors++; $display("FAIL draw3_zero: got dv=%b (%0d,%0d) mv=%b required dv=1 (321,240) mv=0", draw_valid, draw_x, draw_y, cursor_moved); end
        draw_ready = 1'b1;
        tick();
        draw_ready = 1'b0;
        n_checks++; if (draw_valid !== 1'b0) begin n_errors++; $display("FAIL draw3_release: got %b required 0", draw_valid); end
    endtask

    task automatic test_slow_drop();
        int rd0, mv0;
        apply_reset();
        rd0 = n_read;
        mv0 = n_moved;
        start_packet(2, -2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        data_ready = 1'b0;
        n_checks++; if (cursor_x !== 10'd322 || cursor_y !== 10'd242 || draw_valid !== 1'b1) begin n_errors++; $display("FAIL slow_pos: got (%0d,%0d) dv=%b required (322,242) dv=1", cursor_x, cursor_y, draw_valid); end
        draw_ready = 1'b1;
        tick();
        draw_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (n_read - rd0 !== 1) begin n_errors++; $display("FAIL slow_reads: got %0d required 1", n_read - rd0); end
        n_checks++; if (n_moved - mv0 !== 1) begin n_errors++; $display("FAIL slow_updates: got %0d required 1", n_moved - mv0); end
        n_checks++; if (o_state !== 2'd0) begin n_errors++; $display("FAIL slow_state: got %0d required 0", o_state); end
    endtask

    task automatic test_reset_in_draw();
        send_packet("pre_rst", 3, 0, 1'b1, 1'b0);
        n_checks++; if (draw_valid !== 1'b1 || cursor_x !== 10'd325) begin n_errors++; $display("FAIL pre_rst: got dv=%b x=%0d required dv=1 x=325", draw_valid, cursor_x); end
        reset = 1'b1;
        tick();
        n_checks++; if (draw_valid !== 1'b0 || o_state !== 2'd0 || read !== 1'b0) begin n_errors++; $display("FAIL rst_draw_ctl: got dv=%b state=%0d read=%b required 0 0 0", draw_valid, o_state, read); end
        n_checks++; if (cursor_x !== 10'd320 || cursor_y !== 10'd240 || draw_x !== 10'd0) begin n_errors++; $display("FAIL rst_draw_pos: got (%0d,%0d) dx=%0d required (320,240) dx=0", cursor_x, cursor_y, draw_x); end
        reset = 1'b0;
        start_packet(50, 50, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        data_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (cursor_x !== 10'd320 || cursor_y !== 10'd240 || left_button !== 1'b0 || o_state !== 2'd0) begin n_errors++; $display("FAIL rst_ack_discard: got (%0d,%0d) l=%b state=%0d required (320,240) l=0 state=0", cursor_x, cursor_y, left_button, o_state); end
    endtask

    task automatic test_accel();
        logic [9:0] ex1, ex2;
`ifdef CURSOR_ACCEL_EN
        ex1 = 10'd360;
        ex2 = 10'd342;
`else
        ex1 = 10'd340;
        ex2 = 10'd331;
`endif
        apply_reset();
        send_packet("accel1", 20, -3, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== ex1 || cursor_y !== 10'd243) begin n_errors++; $display("FAIL accel1: got (%0d,%0d) required (%0d,243)", cursor_x, cursor_y, ex1); end
        send_packet("accel2", -9, 8, 1'b0, 1'b0);
        n_checks++; if (cursor_x !== ex2 || cursor_y !== 10'd235) begin n_errors++; $display("FAIL accel2: got (%0d,%0d) required (%0d,235)", cursor_x, cursor_y, ex2); end
    endtask

    initial begin
        test_reset();
        test_basic_move();
        test_clamp();
        test_draw_backpressure();
        test_slow_drop();
        test_reset_in_draw();
        test_accel();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1);
    end

endmodule
